// File: rtl/apb_arb_master.sv
// -----------------------------------------------------------------------------
// apb_arb_master
//   Two-requester APB master. Requesters r0/r1 each offer one command
//   (valid/write/prot/addr/wdata/strb). A round-robin arbiter picks one. The
//   winner's command is latched and run as an APB SETUP/ACCESS transfer. The
//   result is returned on that requester's done/rdata/err. A transfer whose
//   ACCESS phase waits TIMEOUT cycles without PREADY is aborted with err=1.
//
// Ports
//   PCLK, PRESET        : clock, synchronous active-high reset
//   rN_valid/write/prot : requester N command valid, direction, protection
//   rN_addr/wdata/strb  : requester N command fields
//   rN_ack              : one-cycle pulse, command captured (first SETUP cycle)
//   rN_done/rdata/err   : one-cycle completion pulse with read data / error
//   PSELx ... PWAKEUP   : APB master request signals (all registered)
//   PREADY/PRDATA/PSLVERR : APB completer response
// -----------------------------------------------------------------------------
module apb_arb_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // requester 0
  input  logic                  r0_valid,
  input  logic                  r0_write,
  input  logic [2:0]            r0_prot,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [STRB_WIDTH-1:0] r0_strb,
  output logic                  r0_ack,
  output logic                  r0_done,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  // requester 1
  input  logic                  r1_valid,
  input  logic                  r1_write,
  input  logic [2:0]            r1_prot,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [STRB_WIDTH-1:0] r1_strb,
  output logic                  r1_ack,
  output logic                  r1_done,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  // APB master
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PWAKEUP,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;      // ACCESS cycles already spent
  logic                       last_q, last_d;    // most recent grant (1 = r1)
  logic                       owner_q, owner_d;  // requester owning the bus transfer
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic                       pwakeup_q, pwakeup_d;
  logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
  logic [2:0]                 pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
  logic [1:0]                 ack_q, ack_d;
  logic [1:0]                 done_q, done_d;
  logic [1:0]                 err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic gnt_any;
  logic gnt_sel;  // winning requester when gnt_any (1 = r1)
  logic grant;

  // Round-robin: on contention the requester not granted last wins.
  assign gnt_any = r0_valid | r1_valid;
  assign gnt_sel = (r0_valid & r1_valid) ? ~last_q : r1_valid;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    // Status outputs are pulses; they read back as 0 outside their cycle.
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = '0;
    grant     = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant = gnt_any;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          done_d[owner_q]  = 1'b1;
          err_d[owner_q]   = PSLVERR;
          rdata_d[owner_q] = pwrite_q ? '0 : PRDATA;
          // Re-arbitrate now so a pending command goes straight to SETUP.
          grant = gnt_any;
          if (!gnt_any) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last allowed ACCESS cycle without PREADY: abort, no re-grant.
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          state_d         = IDLE;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (grant) begin
      state_d        = SETUP;
      psel_d         = 1'b1;
      penable_d      = 1'b0;
      cnt_d          = '0;
      last_d         = gnt_sel;
      owner_d        = gnt_sel;
      ack_d[gnt_sel] = 1'b1;
      // Reads never drive write data or strobes onto the bus.
      if (gnt_sel) begin
        pwrite_d = r1_write;
        pprot_d  = r1_prot;
        paddr_d  = r1_addr;
        pwdata_d = r1_write ? r1_wdata : '0;
        pstrb_d  = r1_write ? r1_strb  : '0;
      end else begin
        pwrite_d = r0_write;
        pprot_d  = r0_prot;
        paddr_d  = r0_addr;
        pwdata_d = r0_write ? r0_wdata : '0;
        pstrb_d  = r0_write ? r0_strb  : '0;
      end
    end

    pwakeup_d = gnt_any | (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and clears every register,
  // including the output flops, so an aborted transfer leaves no pulse behind.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;  // r1 "granted last" so r0 wins the first contention
      owner_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwakeup_q <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwakeup_q <= pwakeup_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign PSELx    = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PPROT    = pprot_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = pstrb_q;
  assign PWAKEUP  = pwakeup_q;

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rdata = rdata_q[0];
  assign r1_rdata = rdata_q[1];

endmodule
